// File: rtl/timer_irq_unit_if.sv
// Bridge-side register bus of the countdown timer: DM address/data path plus the interrupt line.
// The bridge drives through the master modport and the timer sits on the slave modport.
interface timer_irq_unit_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_irq_unit.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes and a maskable interrupt.
// Optional prescaler (PRESCALE register at offset 0xC) is compiled in with `define TIMER_PRESCALE_EN.
module timer_irq_unit #(
  parameter int BASE_OFFSET_BITS = 4,
  parameter int COUNT_W          = 32
) (
  input logic            clk,
  input logic            reset,
  timer_irq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t               state;
  logic                 enable;
  logic [1:0]           mode;
  logic                 im;
  logic [COUNT_W-1:0]   preset;
  logic [COUNT_W-1:0]   count;
  logic                 irq_flag;
  logic [1:0]           reg_sel;
  logic                 ctrl_we;
  logic                 preset_we;
  logic                 auto_reload;
  logic                 tick;
  logic                 unused_addr;

  assign reg_sel     = bus.Addr[BASE_OFFSET_BITS-1:BASE_OFFSET_BITS-2];
  assign unused_addr = ^{bus.Addr[31:BASE_OFFSET_BITS], bus.Addr[BASE_OFFSET_BITS-3:0]};
  assign ctrl_we     = bus.WE && (reg_sel == 2'd0);
  assign preset_we   = bus.WE && (reg_sel == 2'd1);
  assign auto_reload = (mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] div;
  logic        prescale_we;

  assign prescale_we = bus.WE && (reg_sel == 2'd3);
  assign tick        = (div == prescale);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      enable   <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      prescale <= '0;
      div      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (tick) begin
            if (count > COUNT_W'(1)) begin
              count <= count - COUNT_W'(1);
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= S_INT;
            end
          end
        end
        S_INT: begin
          if (auto_reload) irq_flag <= 1'b0;
          else             enable   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef TIMER_PRESCALE_EN
      if (state == S_IDLE || state == S_LOAD) div <= '0;
      else if (state == S_CNT && enable)      div <= tick ? 16'd0 : div + 16'd1;
      if (prescale_we) prescale <= bus.Din[15:0];
`endif

      // NOTE: CPU writes are placed after the FSM so their non-blocking
      // assignments land last and win any same-edge collision on a field.
      if (ctrl_we) begin
        enable   <= bus.Din[0];
        mode     <= bus.Din[2:1];
        im       <= bus.Din[3];
        irq_flag <= 1'b0;
      end
      if (preset_we) begin
        preset   <= bus.Din[COUNT_W-1:0];
        irq_flag <= 1'b0;
      end
    end
  end

  // NOTE: every output of this always_comb gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    bus.Dout = '0;
    case (reg_sel)
      2'd0: bus.Dout = {28'd0, im, mode, enable};
      2'd1: bus.Dout = 32'(preset);
      2'd2: bus.Dout = 32'(count);
`ifdef TIMER_PRESCALE_EN
      2'd3: bus.Dout = {16'd0, prescale};
`else
      2'd3: bus.Dout = '0;
`endif
      default: bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq_flag & im;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Scoreboard bench for timer_irq_unit: expected register/IRQ values are queued as stimulus
// is applied and popped against the DUT when the corresponding cycle is sampled.
module tb_timer_irq_unit;

  logic clk = 1'b0;
  logic reset;

  timer_irq_unit_if bus ();

  timer_irq_unit #(.BASE_OFFSET_BITS(4), .COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    bus.WE   = 1'b0;
    #1;
    d = bus.Dout;
  endtask

  task automatic obs_reg(input logic [31:0] a);
    logic [31:0] d;
    rd(a, d);
    observe(d);
  endtask

  task automatic obs_irq();
    observe({31'd0, bus.IRQ});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt;
    int          n;

    bus.Addr = '0;
    bus.Din  = '0;
    bus.WE   = 1'b0;

    // Reset held with writes attempted: nothing may stick.
    reset    = 1'b0;
    bus.WE   = 1'b1;
    bus.Din  = 32'hFFFF_FFFF;
    bus.Addr = 32'h0;
    @(posedge clk);
    #1;
    bus.Addr = 32'h4;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    for (int a = 0; a < 4; a++) begin
      expect_val($sformatf("rst_reg%0d", a), 32'h0);
      obs_reg(32'(a * 4));
    end
    expect_val("rst_irq", 32'h0);
    obs_irq();
    reset = 1'b1;
    tick();

    // One-shot, PRESET=5, enable+IM at E0.
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    repeat (2) tick();
    expect_val("os_count_e2", 32'd5);  obs_reg(32'h8);
    repeat (4) tick();
    expect_val("os_count_e6", 32'd1);  obs_reg(32'h8);
    expect_val("os_irq_e6", 32'd0);    obs_irq();
    tick();
    expect_val("os_irq_e7", 32'd1);    obs_irq();
    tick();
    expect_val("os_ctrl_e8", 32'h8);   obs_reg(32'h0);
    expect_val("os_irq_e8", 32'd1);    obs_irq();
    repeat (3) tick();
    expect_val("os_irq_hold", 32'd1);  obs_irq();
    wr(32'h0, 32'h8);
    expect_val("os_irq_clear", 32'd0); obs_irq();

    // Auto-reload, PRESET=3: pulse at E0+5 then every 6 cycles.
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 30; k++)
      expect_val($sformatf("ar_irq_k%0d", k), (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      obs_irq();
    end
    expect_val("ar_ctrl", 32'hB); obs_reg(32'h0);
    wr(32'h0, 32'h0);
    repeat (3) tick();

    // Masked one-shot: count completes, IRQ stays low.
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    for (int k = 1; k <= 8; k++) expect_val($sformatf("mask_irq_k%0d", k), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      obs_irq();
    end
    expect_val("mask_count", 32'd0); obs_reg(32'h8);
    expect_val("mask_ctrl", 32'h0);  obs_reg(32'h0);

    // Disable mid-count, then re-enable reloads from PRESET.
    wr(32'h4, 32'd100);
    wr(32'h0, 32'h9);
    n = 0;
    rd(32'h8, cnt);
    while (cnt != 32'd61 && n < 300) begin
      tick();
      rd(32'h8, cnt);
      n++;
    end
    expect_val("dis_poll_61", 32'd61); observe(cnt);
    wr(32'h0, 32'h8);
    repeat (3) tick();
    expect_val("dis_hold_a", 32'd60); obs_reg(32'h8);
    repeat (2) tick();
    expect_val("dis_hold_b", 32'd60); obs_reg(32'h8);
    wr(32'h0, 32'h9);
    expect_val("reen_r0", 32'd60);    obs_reg(32'h8);
    tick();
    expect_val("reen_r1", 32'd60);    obs_reg(32'h8);
    tick();
    expect_val("reen_r2", 32'd100);   obs_reg(32'h8);
    wr(32'h0, 32'h0);
    repeat (3) tick();

    // Collision: CTRL write on the INT edge keeps Enable and restarts.
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    repeat (7) tick();
    expect_val("col_irq_e7", 32'd1);   obs_irq();
    wr(32'h0, 32'h9);
    expect_val("col_ctrl_e8", 32'h9);  obs_reg(32'h0);
    expect_val("col_irq_e8", 32'd0);   obs_irq();
    repeat (2) tick();
    expect_val("col_count_e10", 32'd5); obs_reg(32'h8);
    repeat (4) tick();
    expect_val("col_irq_e14", 32'd0);  obs_irq();
    tick();
    expect_val("col_irq_e15", 32'd1);  obs_irq();
    wr(32'h0, 32'h8);
    repeat (2) tick();

    // Offset 0xC: PRESCALE register when compiled in, otherwise reads 0.
    wr(32'hC, 32'hFFFF_FFFF);
`ifdef TIMER_PRESCALE_EN
    expect_val("off_c_read", 32'h0000_FFFF); obs_reg(32'hC);
    wr(32'hC, 32'd1);
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    repeat (11) tick();
    expect_val("ps_irq_e11", 32'd0); obs_irq();
    tick();
    expect_val("ps_irq_e12", 32'd1); obs_irq();
`else
    expect_val("off_c_read", 32'h0); obs_reg(32'hC);
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
